// File: rtl/aes_encrypt_if.sv
// rtl/aes_encrypt_if.sv - START/DONE handshake and data bundle for the AES-128 encryptor
//
// Purpose: groups the request/response signals of aes_encrypt so that the
// requester and the core share one bundle.
// Signals:
//   AES_START   requester -> core, level request held until AES_DONE is seen
//   AES_KEY     requester -> core, 128-bit cipher key, byte 0 at [127:120]
//   AES_MSG_DEC requester -> core, 128-bit plaintext, byte 0 at [127:120]
//   AES_MSG_ENC core -> requester, 128-bit ciphertext (registered)
//   AES_DONE    core -> requester, completion flag (registered)
// Modports: master (requester side), slave (core side).

interface aes_encrypt_if;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_DEC;
  logic [127:0] AES_MSG_ENC;
  logic         AES_DONE;

  modport master (
    output AES_START, AES_KEY, AES_MSG_DEC,
    input  AES_MSG_ENC, AES_DONE
  );

  modport slave (
    input  AES_START, AES_KEY, AES_MSG_DEC,
    output AES_MSG_ENC, AES_DONE
  );
endinterface

// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-128 encryption core, one round per clock
//
// Purpose: FIPS-197 AES-128 encryption with on-the-fly key expansion and a
// level-sensitive START/DONE handshake.
// Ports:
//   CLK      system clock, all state on the rising edge
//   RESET_N  asynchronous active-low reset
//   bus      aes_encrypt_if.slave (AES_START, AES_KEY, AES_MSG_DEC in;
//            AES_MSG_ENC, AES_DONE out)
// Configuration macro: AES_ENC_TWO_CYCLE_ROUND_EN splits every round into a
// SUB phase and a MIX phase (21-edge latency instead of 11).
// Also contains aes_sbox, the combinational byte S-box shared by all lookups.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry 0 sits in the top byte, so index by the bitwise complement.
  assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_encrypt (
  input  logic        CLK,
  input  logic        RESET_N,
  aes_encrypt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] msg_enc_q;
  logic [3:0]   round_q;
  logic         done_q;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
  logic         phase_q;  // 0: SUB phase, 1: MIX phase
`endif

  logic [127:0] sub_state;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] rk_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (r,c) lives at index r+4c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub_state
      aes_sbox u_sbox (.a(state_q[127-8*gi -: 8]), .y(sub_state[127-8*gi -: 8]));
    end
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
      aes_sbox u_sbox (.a(rot_word[31-8*gi -: 8]), .y(sub_word[31-8*gi -: 8]));
    end
  endgenerate

  assign rot_word = {rk_q[23:0], rk_q[31:24]};
  assign w4       = rk_q[127:96] ^ sub_word ^ {rcon(round_q), 24'h0};
  assign w5       = rk_q[95:64] ^ w4;
  assign w6       = rk_q[63:32] ^ w5;
  assign w7       = rk_q[31:0]  ^ w6;
  assign rk_next  = {w4, w5, w6, w7};

  assign bus.AES_MSG_ENC = msg_enc_q;
  assign bus.AES_DONE    = done_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rk_q      <= '0;
      msg_enc_q <= '0;
      round_q   <= '0;
      done_q    <= 1'b0;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
      phase_q   <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.AES_START) begin
            state_q <= bus.AES_MSG_DEC ^ bus.AES_KEY;
            rk_q    <= bus.AES_KEY;
            round_q <= 4'd1;
            fsm_q   <= ROUND;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
            phase_q <= 1'b0;
`endif
          end
        end
        ROUND: begin
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
          if (!phase_q) begin
            state_q <= sub_state;
            rk_q    <= rk_next;
            phase_q <= 1'b1;
          end else begin
            state_q <= mix_columns(shift_rows(state_q)) ^ rk_q;
            round_q <= round_q + 4'd1;
            phase_q <= 1'b0;
            if (round_q == 4'd9) fsm_q <= FINAL;
          end
`else
          state_q <= mix_columns(shift_rows(sub_state)) ^ rk_next;
          rk_q    <= rk_next;
          round_q <= round_q + 4'd1;
          if (round_q == 4'd9) fsm_q <= FINAL;
`endif
        end
        FINAL: begin
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
          if (!phase_q) begin
            state_q <= sub_state;
            rk_q    <= rk_next;
            phase_q <= 1'b1;
          end else begin
            msg_enc_q <= shift_rows(state_q) ^ rk_q;
            done_q    <= 1'b1;
            phase_q   <= 1'b0;
            fsm_q     <= DONE;
          end
`else
          // round_q is 10 here, so rk_next uses rcon 0x36.
          msg_enc_q <= shift_rows(sub_state) ^ rk_next;
          done_q    <= 1'b1;
          fsm_q     <= DONE;
`endif
        end
        DONE: begin
          // Requester must drop START before another operation can begin.
          if (!bus.AES_START) begin
            done_q <= 1'b0;
            fsm_q  <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - directed self-checking bench for aes_encrypt

module tb_aes_encrypt;
`ifdef AES_ENC_TWO_CYCLE_ROUND_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 11;
`endif
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   edges;
  bit   held;

  aes_encrypt_if bus ();

  aes_encrypt dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", tag, got, exp);
  endtask

  // Called at a negedge: applies inputs with START high, then counts rising
  // edges until DONE is seen. Before DONE, AES_MSG_ENC must keep hold_val.
  task automatic do_run(input logic [127:0] k, input logic [127:0] p,
                        input bit scramble, input bit pulse,
                        input logic [127:0] hold_val,
                        output int n_edges, output bit hold_ok);
    bus.AES_KEY     = k;
    bus.AES_MSG_DEC = p;
    bus.AES_START   = 1'b1;
    n_edges = 0;
    hold_ok = 1'b1;
    while (bus.AES_DONE !== 1'b1 && n_edges < 60) begin
      @(posedge clk);
      n_edges++;
      #1;
      if (n_edges == 1) begin
        if (pulse) bus.AES_START = 1'b0;
        if (scramble) begin
          bus.AES_KEY     = {$urandom, $urandom, $urandom, $urandom};
          bus.AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (bus.AES_DONE !== 1'b1 && bus.AES_MSG_ENC !== hold_val) hold_ok = 1'b0;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.AES_START   = 1'b0;
    bus.AES_KEY     = '0;
    bus.AES_MSG_DEC = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 128'(bus.AES_DONE), 128'd0);
    check("reset_enc", bus.AES_MSG_ENC, 128'd0);

    // FIPS-197 appendix C.1 vector, START held high afterwards.
    @(negedge clk);
    rst_n = 1'b1;
    do_run(K1, P1, 1'b0, 1'b0, 128'd0, edges, held);
    check("lat_run1", 128'(edges), 128'(LAT));
    check("ct_run1", bus.AES_MSG_ENC, C1);
    check("hold_run1", 128'(held), 128'd1);

    repeat (3) @(posedge clk);
    #1;
    check("done_start_held", 128'(bus.AES_DONE), 128'd1);
    check("enc_start_held", bus.AES_MSG_ENC, C1);

    @(negedge clk);
    bus.AES_START = 1'b0;
    @(posedge clk);
    #1;
    check("done_after_drop", 128'(bus.AES_DONE), 128'd0);

    // Back-to-back with the FIPS-197 appendix B vector; inputs scrambled after capture.
    @(negedge clk);
    do_run(K2, P2, 1'b1, 1'b0, C1, edges, held);
    check("lat_run2", 128'(edges), 128'(LAT));
    check("ct_run2", bus.AES_MSG_ENC, C2);
    check("hold_c1_run2", 128'(held), 128'd1);

    // Single-cycle START pulse.
    @(negedge clk);
    bus.AES_START = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_run(K1, P1, 1'b1, 1'b1, C2, edges, held);
    check("lat_pulse", 128'(edges), 128'(LAT));
    check("ct_pulse", bus.AES_MSG_ENC, C1);
    check("hold_c2_pulse", 128'(held), 128'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 128'(bus.AES_DONE), 128'd0);
    check("enc_hold_idle", bus.AES_MSG_ENC, C1);

    // Reset during round 5 with START held high through release.
    @(negedge clk);
    bus.AES_KEY     = K2;
    bus.AES_MSG_DEC = P2;
    bus.AES_START   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_done", 128'(bus.AES_DONE), 128'd0);
    check("midreset_enc", bus.AES_MSG_ENC, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(K2, P2, 1'b0, 1'b0, 128'd0, edges, held);
    check("lat_after_reset", 128'(edges), 128'(LAT));
    check("ct_after_reset", bus.AES_MSG_ENC, C2);
    check("hold_after_reset", 128'(held), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
